alu_issue_ctrl: RTL and testbench

Sequencer and arbiter that shares one alu_simple instance between two requesters, for example the execute stage (port 0) and the address-generation path (port 1). It performs round-robin arbitration and latches the winning command. It then drives the ALU inputs stably for the op's latency, captures the result and flags, and returns them over a valid/ready response channel. It also owns the architectural NZCV flags register, which is updated only when S=1.

---
 rtl/alu_issue_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Shares one ALU between two requesters. Round-robin arbitration,
//            command latching, multi-cycle operand hold, result capture,
//            valid/ready response return and the architectural NZCV register.
// Ports    : clk, rst                      - clock, synchronous active-high reset
//            req{0,1}_valid/ready/cmd      - command channels (93-bit command)
//            alu_in1/in2/opcode/sr_bit/
//            alu_sr_cont/alu_s             - operands driven to the ALU
//            alu_out, alu_flags            - ALU result and NZCV
//            rsp_valid/ready/id/data/err   - response channel
//            flags_q                       - architectural NZCV register
//            busy                          - high whenever not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
   parameter int MUL_CYCLES = 3,
   parameter int ALU_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [92:0] req0_cmd,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [92:0] req1_cmd,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   output logic [3:0]  alu_opcode,
   output logic [4:0]  alu_sr_bit,
   output logic [2:0]  alu_sr_cont,
   output logic        alu_s,
   input  logic [31:0] alu_out,
   input  logic [3:0]  alu_flags,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [3:0]  flags_q,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Counter is loaded with latency-1 so that count 0 marks the last EXEC cycle
   localparam logic [3:0] c_mul_lat = 4'(MUL_CYCLES - 1);
   localparam logic [3:0] c_alu_lat = 4'(ALU_CYCLES - 1);
   localparam logic [3:0] c_op_mul  = 4'b0010;
   localparam logic [3:0] c_op_mov  = 4'b0110;

   state_t      state_q, state_d;
   logic        prio_q, prio_d;         // requester that wins the next tie
   logic [3:0]  cnt_q, cnt_d;
   logic        id_q, id_d;
   logic        sup_q, sup_d;
   logic [31:0] alu_in1_q, alu_in1_d;
   logic [31:0] alu_in2_q, alu_in2_d;
   logic [3:0]  alu_opcode_q, alu_opcode_d;
   logic [4:0]  alu_sr_bit_q, alu_sr_bit_d;
   logic [2:0]  alu_sr_cont_q, alu_sr_cont_d;
   logic        alu_s_q, alu_s_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_id_q, rsp_id_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        rsp_err_q, rsp_err_d;
   logic [3:0]  flags_d;

   logic        w_idle;
   logic        w_grant1;
   logic        w_accept;
   logic [92:0] w_cmd;
   logic [3:0]  w_op;

   function automatic logic is_supported(input logic [3:0] op);
      return (op[3] == 1'b0) || (op == 4'b1101) || (op == 4'b1110);
   endfunction

   // Arbitration: a lone valid wins; on a tie the prioritised requester wins
   assign w_idle     = (state_q == ST_IDLE);
   assign w_grant1   = (req0_valid && req1_valid) ? prio_q : (req1_valid && !req0_valid);
   assign req0_ready = w_idle && req0_valid && !w_grant1;
   assign req1_ready = w_idle && req1_valid && w_grant1;
   assign w_accept   = req0_ready || req1_ready;
   assign w_cmd      = w_grant1 ? req1_cmd : req0_cmd;
   assign w_op       = w_cmd[91:88];

   always_comb begin
      state_d       = state_q;
      prio_d        = prio_q;
      cnt_d         = cnt_q;
      id_d          = id_q;
      sup_d         = sup_q;
      alu_in1_d     = alu_in1_q;
      alu_in2_d     = alu_in2_q;
      alu_opcode_d  = alu_opcode_q;
      alu_sr_bit_d  = alu_sr_bit_q;
      alu_sr_cont_d = alu_sr_cont_q;
      alu_s_d       = alu_s_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_id_d      = rsp_id_q;
      rsp_data_d    = rsp_data_q;
      rsp_err_d     = rsp_err_q;
      flags_d       = flags_q;

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               state_d       = ST_EXEC;
               id_d          = w_grant1;
               prio_d        = !w_grant1;
               sup_d         = is_supported(w_op);
               cnt_d         = (w_op == c_op_mul) ? c_mul_lat : c_alu_lat;
               alu_s_d       = w_cmd[92];
               alu_opcode_d  = w_op;
               alu_in1_d     = w_cmd[87:56];
               // MOV immediate takes its operand from the zero-extended imm field
               alu_in2_d     = (w_op == c_op_mov) ? {16'b0, w_cmd[15:0]} : w_cmd[55:24];
               alu_sr_bit_d  = w_cmd[23:19];
               alu_sr_cont_d = w_cmd[18:16];
            end
         end
         ST_EXEC: begin
            if (cnt_q == 4'd0) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_id_d    = id_q;
               rsp_data_d  = sup_q ? alu_out : 32'd0;
               rsp_err_d   = !sup_q;
               if (sup_q && alu_s_q) begin
                  flags_d = alu_flags;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         prio_q        <= 1'b0;
         cnt_q         <= 4'd0;
         id_q          <= 1'b0;
         sup_q         <= 1'b0;
         alu_in1_q     <= 32'd0;
         alu_in2_q     <= 32'd0;
         alu_opcode_q  <= 4'd0;
         alu_sr_bit_q  <= 5'd0;
         alu_sr_cont_q <= 3'd0;
         alu_s_q       <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= 1'b0;
         rsp_data_q    <= 32'd0;
         rsp_err_q     <= 1'b0;
         flags_q       <= 4'd0;
      end else begin
         state_q       <= state_d;
         prio_q        <= prio_d;
         cnt_q         <= cnt_d;
         id_q          <= id_d;
         sup_q         <= sup_d;
         alu_in1_q     <= alu_in1_d;
         alu_in2_q     <= alu_in2_d;
         alu_opcode_q  <= alu_opcode_d;
         alu_sr_bit_q  <= alu_sr_bit_d;
         alu_sr_cont_q <= alu_sr_cont_d;
         alu_s_q       <= alu_s_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_id_q      <= rsp_id_d;
         rsp_data_q    <= rsp_data_d;
         rsp_err_q     <= rsp_err_d;
         flags_q       <= flags_d;
      end
   end

   assign alu_in1     = alu_in1_q;
   assign alu_in2     = alu_in2_q;
   assign alu_opcode  = alu_opcode_q;
   assign alu_sr_bit  = alu_sr_bit_q;
   assign alu_sr_cont = alu_sr_cont_q;
   assign alu_s       = alu_s_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_err     = rsp_err_q;
   assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Directed self-checking bench for alu_issue_ctrl. A small
//            behavioural ALU stub answers the operands the DUT drives.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [92:0] req0_cmd, req1_cmd;
   logic [31:0] alu_in1, alu_in2;
   logic [3:0]  alu_opcode;
   logic [4:0]  alu_sr_bit;
   logic [2:0]  alu_sr_cont;
   logic        alu_s;
   logic [31:0] alu_out;
   logic [3:0]  alu_flags;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
   logic [31:0] rsp_data;
   logic [3:0]  flags_q;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.MUL_CYCLES(3), .ALU_CYCLES(1)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode),
      .alu_sr_bit(alu_sr_bit), .alu_sr_cont(alu_sr_cont), .alu_s(alu_s),
      .alu_out(alu_out), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .flags_q(flags_q), .busy(busy)
   );

   // ALU stub; flags = {N, Z, 1, 0} so every update is visible on C
   always_comb begin
      case (alu_opcode)
         4'b0000: alu_out = alu_in1 + alu_in2;
         4'b0001: alu_out = alu_in1 - alu_in2;
         4'b0010: alu_out = alu_in1 * alu_in2;
         4'b0110: alu_out = alu_in2;
         4'b1101: alu_out = alu_in1;
         4'b1110: alu_out = alu_in1;
         default: alu_out = 32'd0;
      endcase
      alu_flags = {alu_out[31], (alu_out == 32'd0), 1'b1, 1'b0};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [92:0] mk(input logic s, input logic [3:0] op,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [15:0] imm);
      return {s, op, a, b, 5'd3, 3'd2, imm};
   endfunction

   // Issue on one port, check the hold window of lat cycles, end at RESP
   task automatic issue(input logic port, input logic [92:0] cmd, input int lat,
                        input logic [31:0] exp_in2);
      if (port) begin req1_valid = 1'b1; req1_cmd = cmd; end
      else      begin req0_valid = 1'b1; req0_cmd = cmd; end
      #1;
      chk("ready0", {31'd0, req0_ready}, {31'd0, !port});
      chk("ready1", {31'd0, req1_ready}, {31'd0, port});
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      for (int i = 0; i < lat; i++) begin
         chk("exec_busy", {31'd0, busy}, 32'd1);
         chk("exec_rv", {31'd0, rsp_valid}, 32'd0);
         chk("exec_in1", alu_in1, cmd[87:56]);
         chk("exec_in2", alu_in2, exp_in2);
         chk("exec_op", {28'd0, alu_opcode}, {28'd0, cmd[91:88]});
         chk("exec_srb", {27'd0, alu_sr_bit}, 32'd3);
         chk("exec_src", {29'd0, alu_sr_cont}, 32'd2);
         chk("exec_s", {31'd0, alu_s}, {31'd0, cmd[92]});
         tick();
      end
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("hs_rv", {31'd0, rsp_valid}, 32'd0);
      chk("hs_busy", {31'd0, busy}, 32'd0);
   endtask

   task automatic expect_rsp(input logic id, input logic [31:0] data,
                             input logic err, input logic [3:0] flags);
      chk("rsp_id", {31'd0, rsp_id}, {31'd0, id});
      chk("rsp_data", rsp_data, data);
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, err});
      chk("flags", {28'd0, flags_q}, {28'd0, flags});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      req0_cmd = '0; req1_cmd = '0;

      // Reset state
      do_reset();
      chk("rst_rv", {31'd0, rsp_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_flags", {28'd0, flags_q}, 32'd0);
      chk("rst_in1", alu_in1, 32'd0);
      chk("rst_data", rsp_data, 32'd0);

      // ADD 15+20, S=1 -> 35, flags {0,0,1,0}
      issue(1'b0, mk(1'b1, 4'b0000, 32'd15, 32'd20, 16'd0), 1, 32'd20);
      expect_rsp(1'b0, 32'd35, 1'b0, 4'b0010);
      handshake();

      // Tie arbitration after reset: 0, 1, 0
      do_reset();
      for (int r = 0; r < 3; r++) begin
         logic exp_id;
         exp_id = (r == 1);
         req0_valid = 1'b1; req0_cmd = mk(1'b0, 4'b0000, 32'd1, 32'd1, 16'd0);
         req1_valid = 1'b1; req1_cmd = mk(1'b0, 4'b0000, 32'd2, 32'd2, 16'd0);
         #1;
         chk("tie_r0", {31'd0, req0_ready}, {31'd0, !exp_id});
         chk("tie_r1", {31'd0, req1_ready}, {31'd0, exp_id});
         tick();
         chk("busy_r0", {31'd0, req0_ready}, 32'd0);
         chk("busy_r1", {31'd0, req1_ready}, 32'd0);
         req0_valid = 1'b0; req1_valid = 1'b0;
         tick();
         chk("tie_rv", {31'd0, rsp_valid}, 32'd1);
         expect_rsp(exp_id, exp_id ? 32'd4 : 32'd2, 1'b0, 4'b0000);
         handshake();
      end

      // SUB 7-7, S=1 -> 0, flags {0,1,1,0}
      issue(1'b0, mk(1'b1, 4'b0001, 32'd7, 32'd7, 16'd0), 1, 32'd7);
      expect_rsp(1'b0, 32'd0, 1'b0, 4'b0110);
      handshake();

      // MUL 5*5 on port 1, S=0, three-cycle hold; flags unchanged
      issue(1'b1, mk(1'b0, 4'b0010, 32'd5, 32'd5, 16'd0), 3, 32'd5);
      expect_rsp(1'b1, 32'd25, 1'b0, 4'b0110);
      handshake();

      // MOV imm=60 with in2 all ones, S=1 -> 60, flags {0,0,1,0}
      issue(1'b0, mk(1'b1, 4'b0110, 32'd0, 32'hFFFF_FFFF, 16'd60), 1, 32'd60);
      expect_rsp(1'b0, 32'd60, 1'b0, 4'b0010);
      handshake();

      // LDR passes In1 through
      issue(1'b1, mk(1'b0, 4'b1101, 32'hDEAD_BEEF, 32'd1, 16'd0), 1, 32'd1);
      expect_rsp(1'b1, 32'hDEAD_BEEF, 1'b0, 4'b0010);
      handshake();

      // Unsupported opcode 1111, S=1 -> err, data 0, flags unchanged
      issue(1'b0, mk(1'b1, 4'b1111, 32'd9, 32'd9, 16'd0), 1, 32'd9);
      expect_rsp(1'b0, 32'd0, 1'b1, 4'b0010);
      handshake();

      // Back-pressure for 5 cycles with both requesters waiting
      issue(1'b1, mk(1'b0, 4'b0000, 32'd3, 32'd4, 16'd0), 1, 32'd4);
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_rv", {31'd0, rsp_valid}, 32'd1);
         chk("bp_data", rsp_data, 32'd7);
         chk("bp_id", {31'd0, rsp_id}, 32'd1);
         chk("bp_r0", {31'd0, req0_ready}, 32'd0);
         chk("bp_r1", {31'd0, req1_ready}, 32'd0);
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      handshake();

      // Reset mid-EXEC of a multiply: no response, everything cleared
      req0_valid = 1'b1; req0_cmd = mk(1'b1, 4'b0010, 32'd6, 32'd7, 16'd0);
      tick();
      req0_valid = 1'b0;
      chk("mid_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_busy", {31'd0, busy}, 32'd0);
      chk("mr_rv", {31'd0, rsp_valid}, 32'd0);
      chk("mr_in1", alu_in1, 32'd0);
      chk("mr_in2", alu_in2, 32'd0);
      chk("mr_op", {28'd0, alu_opcode}, 32'd0);
      chk("mr_flags", {28'd0, flags_q}, 32'd0);
      chk("mr_data", rsp_data, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mr_norsp", {31'd0, rsp_valid}, 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
